// File: rtl/instr_mem_sync.sv
`default_nettype none
// instr_mem_sync: word-addressed instruction memory with one-cycle registered fetch, stall/flush and fault flag.
// Optional sequential bulk loader (ports + IDLE/LOAD FSM) is built only when IMEM_LOAD_PORT_EN is defined.
module instr_mem_sync #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
`ifdef IMEM_LOAD_PORT_EN
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count,
`endif
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fault
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] word_idx;
  logic              addr_fault;
  logic [DATA_W-1:0] rd_word;
  logic              busy;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  // DEPTH never exceeds 2**ADDR_W, so any set bit above the index field is out of range.
  assign word_idx   = pc[ADDR_W+1:2];
  assign addr_fault = (pc[1:0] != 2'b00) || (|pc[31:ADDR_W+2]) || ({1'b0, word_idx} >= DEPTH_W);

`ifdef IMEM_LOAD_PORT_EN
  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } load_state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  load_state_t       state_q;
  logic [ADDR_W:0]   count_q;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  assign busy       = (state_q == S_LOAD);
  assign load_busy  = busy;
  assign load_count = count_q;
  assign mem_we     = busy && load_valid && !reset;
  assign rd_word    = mem_q[word_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LOAD;
            count_q <= '0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            count_q <= count_q + (ADDR_W+1)'(1);
            if (count_q == LAST_IDX) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset: an aborted load keeps whatever words were already written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q[ADDR_W-1:0]] <= load_data;
    end
  end
`else
  // Without the loader the contents can never leave their power-up value.
  assign busy    = 1'b0;
  assign rd_word = NOP_WORD;
`endif

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
    end else if (busy || !fetch_en) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (addr_fault) begin
      instr_d = NOP_WORD;
      valid_d = 1'b1;
      fault_d = 1'b1;
    end else begin
      instr_d = rd_word;
      valid_d = 1'b1;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
`default_nettype none
// Self-checking bench for instr_mem_sync: directed fetch/stall/flush/loader cases, then randomized traffic
// compared every cycle against a behavioural model of the fetch and loader rules.
module tb_instr_mem_sync;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 256;
  // Nonzero bubble value so a NOP is distinguishable from a zero word.
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_en;
  logic              stall;
  logic              flush;
  logic [31:0]       pc;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              fault;
`ifdef IMEM_LOAD_PORT_EN
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_busy;
  logic [ADDR_W:0]   load_count;
`endif

  always #5 clk = ~clk;

  instr_mem_sync #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .fetch_en   (fetch_en),
    .stall      (stall),
    .flush      (flush),
`ifdef IMEM_LOAD_PORT_EN
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_busy  (load_busy),
    .load_count (load_count),
`endif
    .instruction(instruction),
    .instr_valid(instr_valid),
    .fault      (fault)
  );

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_instr;
  logic        e_valid;
  logic        e_fault;
  logic        m_busy;
  int          m_count;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply the rules for one rising edge using the inputs presented before it.
  task automatic model_edge();
    logic busy_now;
    busy_now = m_busy;
    if (reset) begin
      e_instr = NOP;
      e_valid = 1'b0;
      e_fault = 1'b0;
      m_busy  = 1'b0;
      m_count = 0;
    end else begin
      if (flush) begin
        e_instr = NOP;
        e_valid = 1'b0;
        e_fault = 1'b0;
      end else if (stall) begin
        e_valid = e_valid;
      end else if (!fetch_en || busy_now) begin
        e_instr = NOP;
        e_valid = 1'b0;
        e_fault = 1'b0;
      end else if ((pc % 4) != 0 || (pc / 4) >= DEPTH) begin
        e_instr = NOP;
        e_valid = 1'b1;
        e_fault = 1'b1;
      end else begin
        e_instr = m_mem[pc / 4];
        e_valid = 1'b1;
        e_fault = 1'b0;
      end
`ifdef IMEM_LOAD_PORT_EN
      if (!m_busy) begin
        if (load_start) begin
          m_busy  = 1'b1;
          m_count = 0;
        end
      end else if (load_valid) begin
        m_mem[m_count] = load_data;
        m_count++;
        if (m_count == DEPTH) m_busy = 1'b0;
      end
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("instruction", instruction, e_instr);
    chk("instr_valid", instr_valid, e_valid);
    chk("fault", fault, e_fault);
`ifdef IMEM_LOAD_PORT_EN
    chk("load_busy", load_busy, m_busy);
    chk("load_count", load_count, m_count);
`endif
  endtask

  task automatic rand_inputs();
    int sel;
    reset    = ($urandom_range(0, 199) == 0);
    flush    = ($urandom_range(0, 9) == 0);
    stall    = ($urandom_range(0, 5) == 0);
    fetch_en = ($urandom_range(0, 4) != 0);
    sel      = $urandom_range(0, 9);
    if (sel < 6)       pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (sel < 8)  pc = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else if (sel == 8) pc = 32'h400 + 32'($urandom_range(0, 15)) * 4;
    else               pc = $urandom;
`ifdef IMEM_LOAD_PORT_EN
    load_start = ($urandom_range(0, 299) == 0);
    load_valid = ($urandom_range(0, 2) != 0);
    load_data  = $urandom;
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    e_instr = NOP; e_valid = 1'b0; e_fault = 1'b0; m_busy = 1'b0; m_count = 0;
    reset = 1'b1; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; pc = '0;
`ifdef IMEM_LOAD_PORT_EN
    load_start = 1'b0; load_valid = 1'b0; load_data = '0;
`endif

    // Reset state
    fetch_en = 1'b1;
    repeat (2) cycle();
    chk("rst_instr", instruction, NOP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;

    // Misaligned, out of range, last legal word, idle
    pc = 32'h0E;  cycle();
    chk("misaligned_fault", fault, 1);
    chk("misaligned_valid", instr_valid, 1);
    chk("misaligned_instr", instruction, NOP);
    pc = 32'h400; cycle();
    chk("oor_fault", fault, 1);
    pc = 32'h3FC; cycle();
    chk("last_word_fault", fault, 0);
    chk("last_word_valid", instr_valid, 1);
    fetch_en = 1'b0; cycle();
    chk("idle_valid", instr_valid, 0);
    chk("idle_instr", instruction, NOP);

`ifdef IMEM_LOAD_PORT_EN
    // Partial load aborted by reset; word 3 carries a real opcode
    fetch_en = 1'b1; pc = 32'h0C;
    load_start = 1'b1; cycle(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 3) ? 32'h8C01_0000 : 32'(i);
      cycle();
      chk("busy_fetch_valid", instr_valid, 0);
    end
    load_valid = 1'b0; reset = 1'b1; cycle(); reset = 1'b0;
    chk("abort_busy", load_busy, 0);
    chk("abort_count", load_count, 0);
    for (int i = 0; i < 6; i++) begin
      pc = 32'(i * 4); cycle();
    end
    pc = 32'h0C; cycle();
    chk("word3_instr", instruction, 32'h8C01_0000);
    chk("word3_valid", instr_valid, 1);
    chk("word3_fault", fault, 0);
    pc = 32'h14; cycle();
    chk("word5_untouched", instruction, NOP);

    // Full load of data=index with gaps and a stray load_start mid-load
    load_start = 1'b1; cycle(); load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(i);
      load_start = (i == 100);
      cycle();
      load_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) cycle();
    end
    load_start = 1'b0;
    chk("full_busy", load_busy, 0);
    chk("full_count", load_count, DEPTH);
    cycle();
    chk("full_count_held", load_count, DEPTH);
    pc = 32'h3FC; cycle();
    chk("full_last_word", instruction, 32'h0000_00FF);
`endif

    // Stall holds the registered fetch; flush wins over stall
    fetch_en = 1'b1; pc = 32'h0C; cycle();
    stall = 1'b1; pc = 32'h10;
    repeat (3) begin
      cycle();
`ifdef IMEM_LOAD_PORT_EN
      chk("stall_hold", instruction, 32'h3);
`else
      chk("stall_hold", instruction, NOP);
`endif
      chk("stall_valid", instr_valid, 1);
    end
    flush = 1'b1; cycle();
    chk("flush_valid", instr_valid, 0);
    chk("flush_instr", instruction, NOP);
    stall = 1'b0; flush = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, word-index width; word index = pc[ADDR_W+1:2].
REQ-003 SHALL have parameter DEPTH, default 256, number of words, at most 2**ADDR_W.
REQ-004 SHALL have parameter NOP_WORD, default 0, bubble/fill value.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pc, input, 32 bits: byte address of fetch.
REQ-008 SHALL have port fetch_en, input, 1 bit: request a fetch this cycle.
REQ-009 SHALL have port stall, input, 1 bit: hold the output registers.
REQ-010 SHALL have port flush, input, 1 bit: insert a bubble.
REQ-011 SHALL have port instruction, output, DATA_W bits: registered fetched word.
REQ-012 SHALL have port instr_valid, output, 1 bit: instruction is a real fetch result.
REQ-013 SHALL have port fault, output, 1 bit: last fetch was misaligned or out of range.
REQ-014 SHALL have, only under IMEM_LOAD_PORT_EN, the following ports: load_start (input, 1 bit), load_valid (input, 1 bit), load_data (input, DATA_W bits), load_busy (output, 1 bit) and load_count (output, ADDR_W+1 bits).

Function
REQ-015 SHALL have single-cycle read latency: pc is sampled at edge N and instruction is valid after edge N.
REQ-016 SHALL apply per-edge priority reset > flush > stall > load_busy > fetch_en.
REQ-017 On flush: instruction=NOP_WORD, instr_valid=0, fault=0.
REQ-018 On stall without flush: instruction, instr_valid and fault SHALL hold their values.
REQ-019 With fetch_en=0 (no stall/flush): instruction=NOP_WORD, instr_valid=0, fault=0.
REQ-020 A fetch SHALL fault if pc[1:0]!=0 or pc[31:2]>=DEPTH.
REQ-021 A faulting fetch SHALL give instruction=NOP_WORD, instr_valid=1, fault=1.
REQ-022 A non-faulting fetch SHALL give instruction=mem[pc[ADDR_W+1:2]], instr_valid=1, fault=0.
REQ-023 All memory words SHALL power up to NOP_WORD; memory SHALL NOT be cleared by reset.
REQ-024 Loader FSM states: IDLE and LOAD.
REQ-025 IDLE→LOAD on load_start: load_count=0, load_busy=1.
REQ-026 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[load_count] and increment load_count.
REQ-027 The write at load_count=DEPTH-1 SHALL return the FSM to IDLE (load_busy=0), with load_count=DEPTH held until the next load_start.
REQ-028 load_start while in LOAD SHALL be ignored; load_valid while in IDLE SHALL be ignored.
REQ-029 While load_busy=1, a fetch SHALL be suppressed and behave as fetch_en=0 (REQ-019); no read/write collision is possible.

Reset
REQ-030 On reset: instruction=NOP_WORD, instr_valid=0, fault=0, FSM=IDLE, load_busy=0, load_count=0.
REQ-031 Reset mid-load SHALL abort the load and retain words already written.

Configuration
REQ-032 The macro IMEM_LOAD_PORT_EN SHALL control the loader.
REQ-033 With IMEM_LOAD_PORT_EN defined: the loader ports and FSM are present and behave per REQ-024..029.
REQ-034 Without IMEM_LOAD_PORT_EN: the loader ports and FSM are absent, memory is read-only after power-up, and load_busy is internally treated as 0.

Verification
REQ-035 Load 0x8C010000 at index 3 via the loader, release, fetch pc=0x0C → instruction=0x8C010000 one edge later, instr_valid=1, fault=0.
REQ-036 Fetch pc=0x0E → fault=1, instr_valid=1, instruction=0x00000000; fetch pc=0x400 (DEPTH=256) → fault=1.
REQ-037 Fetch pc=0x0C, then stall=1 for 3 cycles while pc=0x10 → output stays at word 3; stall+flush together → instr_valid=0 and instruction=NOP.
REQ-038 load_start, then 256 load_valid beats of data=index → load_busy drops after beat 256, load_count=256; fetch pc=0x3FC → 0x000000FF.
REQ-039 Assert reset after 5 load beats → load_busy=0, load_count=0; words 0–4 readable and word 5 = NOP.
REQ-040 fetch_en=1 while load_busy=1 → instr_valid=0 every cycle of the load.
